// File: rtl/spike_rate_monitor_if.sv
// Spike monitor bundle: neuron-side controls/spike in, rate and ISI observations out.
// The master drives ena/clear/spike; the slave (the monitor) drives the result fields.
interface spike_rate_monitor_if #(
    parameter int CNT_W = 8,
    parameter int ISI_W = 8
);
    logic             ena;
    logic             clear;
    logic             spike;
    logic             spike_edge;
    logic [CNT_W-1:0] rate;
    logic             rate_valid;
    logic [ISI_W-1:0] isi;
    logic             isi_ovf;
    logic             isi_valid;

    modport master (
        output ena, clear, spike,
        input  spike_edge, rate, rate_valid, isi, isi_ovf, isi_valid
    );

    modport slave (
        input  ena, clear, spike,
        output spike_edge, rate, rate_valid, isi, isi_ovf, isi_valid
    );
endinterface

// File: rtl/spike_rate_monitor.sv
// Spike edge detector with windowed rate counter and inter-spike-interval timer.
// All outputs registered, one cycle after the qualifying edge; no backpressure, ena freezes all timing.
module spike_rate_monitor #(
    parameter int WINDOW_LOG2 = 8,
    parameter int CNT_W       = 8,
    parameter int ISI_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    spike_rate_monitor_if.slave mon
);
    typedef enum logic {IDLE, TIMING} isi_state_e;

    localparam logic [CNT_W-1:0] RATE_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_MAX  = '1;

    logic                   spike_q, spike_d;
    logic                   edge_q, edge_d;
    logic [WINDOW_LOG2-1:0] win_q, win_d;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]       rate_q, rate_d;
    logic                   rate_vld_q, rate_vld_d;
    logic [ISI_W-1:0]       isi_cnt_q, isi_cnt_d;
    logic [ISI_W-1:0]       isi_q, isi_d;
    logic                   isi_ovf_q, isi_ovf_d;
    logic                   isi_vld_q, isi_vld_d;
    isi_state_e             state_q, state_d;

    logic                   edge_c;
    logic                   terminal_c;
    logic [CNT_W-1:0]       acc_sat_c;

    // spike_q samples regardless of ena, so a spike that rose while disabled is never seen as an edge
    assign edge_c     = mon.spike & ~spike_q & mon.ena;
    assign terminal_c = mon.ena & (&win_q);
    assign acc_sat_c  = (edge_c && (acc_q != RATE_MAX)) ? acc_q + CNT_W'(1) : acc_q;

    always_comb begin
        spike_d    = mon.spike;
        edge_d     = edge_c;
        win_d      = win_q;
        acc_d      = acc_q;
        rate_d     = rate_q;
        rate_vld_d = 1'b0;
        isi_cnt_d  = isi_cnt_q;
        isi_d      = isi_q;
        isi_ovf_d  = isi_ovf_q;
        isi_vld_d  = 1'b0;
        state_d    = state_q;

        if (mon.ena) begin
            win_d = win_q + WINDOW_LOG2'(1);
            // an edge on the terminal cycle still belongs to the window being closed
            if (terminal_c) begin
                rate_d     = acc_sat_c;
                acc_d      = '0;
                rate_vld_d = 1'b1;
            end else begin
                acc_d = acc_sat_c;
            end
        end

        case (state_q)
            IDLE: begin
                if (edge_c) begin
                    state_d   = TIMING;
                    isi_cnt_d = ISI_W'(1);
                end
            end
            TIMING: begin
                if (edge_c) begin
                    isi_d     = isi_cnt_q;
                    isi_ovf_d = (isi_cnt_q == ISI_MAX);
                    isi_vld_d = 1'b1;
                    isi_cnt_d = ISI_W'(1);
                end else if (mon.ena && (isi_cnt_q != ISI_MAX)) begin
                    isi_cnt_d = isi_cnt_q + ISI_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (mon.clear) begin
            spike_d    = 1'b0;
            edge_d     = 1'b0;
            win_d      = '0;
            acc_d      = '0;
            rate_d     = '0;
            rate_vld_d = 1'b0;
            isi_cnt_d  = '0;
            isi_d      = '0;
            isi_ovf_d  = 1'b0;
            isi_vld_d  = 1'b0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_q    <= 1'b0;
            edge_q     <= 1'b0;
            win_q      <= '0;
            acc_q      <= '0;
            rate_q     <= '0;
            rate_vld_q <= 1'b0;
            isi_cnt_q  <= '0;
            isi_q      <= '0;
            isi_ovf_q  <= 1'b0;
            isi_vld_q  <= 1'b0;
            state_q    <= IDLE;
        end else begin
            spike_q    <= spike_d;
            edge_q     <= edge_d;
            win_q      <= win_d;
            acc_q      <= acc_d;
            rate_q     <= rate_d;
            rate_vld_q <= rate_vld_d;
            isi_cnt_q  <= isi_cnt_d;
            isi_q      <= isi_d;
            isi_ovf_q  <= isi_ovf_d;
            isi_vld_q  <= isi_vld_d;
            state_q    <= state_d;
        end
    end

    assign mon.spike_edge = edge_q;
    assign mon.rate       = rate_q;
    assign mon.rate_valid = rate_vld_q;
    assign mon.isi        = isi_q;
    assign mon.isi_ovf    = isi_ovf_q;
    assign mon.isi_valid  = isi_vld_q;
endmodule

// File: tb/tb_spike_rate_monitor.sv
// Bench for spike_rate_monitor: directed scenarios then random traffic, every cycle
// compared against a timestamp-based reference model.
module tb_spike_rate_monitor;
    localparam int WL   = 4;
    localparam int CW   = 3;
    localparam int IW   = 4;
    localparam int WIN  = 1 << WL;
    localparam int CMAX = (1 << CW) - 1;
    localparam int IMAX = (1 << IW) - 1;

    logic clk;
    logic rst_n;

    spike_rate_monitor_if #(.CNT_W(CW), .ISI_W(IW)) bus ();

    spike_rate_monitor #(.WINDOW_LOG2(WL), .CNT_W(CW), .ISI_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model: ena-cycle timestamps and plain edge counts
    int m_prev, m_tick, m_edges, m_last, m_have_last;
    int e_edge, e_rate, e_rvld, e_isi, e_ovf, e_ivld;
    int n_se, n_iv, n_rv;

    task automatic model_reset();
        m_prev = 0; m_tick = 0; m_edges = 0; m_last = 0; m_have_last = 0;
        e_edge = 0; e_rate = 0; e_rvld = 0; e_isi = 0; e_ovf = 0; e_ivld = 0;
    endtask

    task automatic model_step();
        int is_edge;
        int gap;
        if (bus.clear) begin
            model_reset();
            return;
        end
        is_edge = (bus.spike && (m_prev == 0) && bus.ena) ? 1 : 0;
        m_prev  = bus.spike ? 1 : 0;
        e_edge  = is_edge;
        e_rvld  = 0;
        e_ivld  = 0;
        if (bus.ena) begin
            if (is_edge != 0) begin
                m_edges++;
                if (m_have_last != 0) begin
                    gap    = m_tick - m_last;
                    e_isi  = (gap > IMAX) ? IMAX : gap;
                    e_ovf  = (gap >= IMAX) ? 1 : 0;
                    e_ivld = 1;
                end
                m_last      = m_tick;
                m_have_last = 1;
            end
            if ((m_tick % WIN) == WIN - 1) begin
                e_rate  = (m_edges > CMAX) ? CMAX : m_edges;
                e_rvld  = 1;
                m_edges = 0;
            end
            m_tick++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("spike_edge", 32'(bus.spike_edge), e_edge);
        chk("rate",       32'(bus.rate),       e_rate);
        chk("rate_valid", 32'(bus.rate_valid), e_rvld);
        chk("isi",        32'(bus.isi),        e_isi);
        chk("isi_ovf",    32'(bus.isi_ovf),    e_ovf);
        chk("isi_valid",  32'(bus.isi_valid),  e_ivld);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
        if (bus.spike_edge === 1'b1) n_se++;
        if (bus.isi_valid === 1'b1)  n_iv++;
        if (bus.rate_valid === 1'b1) n_rv++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        n_se = 0; n_iv = 0; n_rv = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rv;
        rst_n = 1'b0;
        bus.ena = 1'b0; bus.clear = 1'b0; bus.spike = 1'b0;
        model_reset();
        n_se = 0; n_iv = 0; n_rv = 0;
        repeat (2) @(negedge clk);
        check_all();
        rst_n   = 1'b1;
        bus.ena = 1'b1;

        // held spike: one edge, rate 1, no ISI
        run(3);
        bus.spike = 1'b1; run(5);
        bus.spike = 1'b0; run(8);
        chk("held_edges", 32'(n_se), 1);
        chk("held_isi_valid", 32'(n_iv), 0);
        chk("held_rate", 32'(bus.rate), 1);

        // periodic: 1-cycle spike every 8 cycles
        do_clear();
        for (int i = 0; i < 64; i++) begin
            bus.spike = ((i % 8) == 0);
            cyc();
        end
        bus.spike = 1'b0;
        chk("per_isi_valid_cnt", 32'(n_iv), 7);
        chk("per_rate_valid_cnt", 32'(n_rv), 4);
        chk("per_isi", 32'(bus.isi), 8);
        chk("per_isi_ovf", 32'(bus.isi_ovf), 0);
        chk("per_rate", 32'(bus.rate), 2);

        // saturation: toggle every cycle, then a long gap
        do_clear();
        for (int i = 0; i < 16; i++) begin
            bus.spike = ((i % 2) == 0);
            cyc();
        end
        chk("sat_rate", 32'(bus.rate), CMAX);
        bus.spike = 1'b0; run(20);
        bus.spike = 1'b1; cyc();
        bus.spike = 1'b0;
        chk("sat_isi", 32'(bus.isi), IMAX);
        chk("sat_isi_ovf", 32'(bus.isi_ovf), 1);
        run(2);

        // edge on the terminal cycle
        do_clear();
        run(15);
        bus.spike = 1'b1; cyc();
        bus.spike = 1'b0;
        chk("term_rate_valid", 32'(bus.rate_valid), 1);
        chk("term_rate", 32'(bus.rate), 1);
        run(16);
        chk("term_next_rate", 32'(bus.rate), 0);

        // ena low between edges, then clear back to IDLE
        do_clear();
        bus.spike = 1'b1; cyc();
        bus.spike = 1'b0; run(5);
        n_se = 0;
        bus.ena = 1'b0; run(3);
        bus.spike = 1'b1; run(2);
        bus.spike = 1'b0; run(5);
        chk("ena_low_edges", 32'(n_se), 0);
        bus.ena = 1'b1;
        bus.spike = 1'b1; cyc();
        bus.spike = 1'b0;
        chk("ena_isi", 32'(bus.isi), 6);
        cyc();
        do_clear();
        chk("clr_rate", 32'(bus.rate), 0);
        chk("clr_isi", 32'(bus.isi), 0);
        bus.spike = 1'b1; cyc();
        bus.spike = 1'b0; run(3);
        chk("clr_first_edge_isi_valid", 32'(n_iv), 0);
        chk("clr_first_edge_pulse", 32'(n_se), 1);

        // async reset mid-window
        bus.spike = 1'b1; cyc();
        bus.spike = 1'b0; run(4);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        first_rv = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (first_rv < 0 && bus.rate_valid === 1'b1) first_rv = i;
        end
        chk("rst_first_rate_valid", first_rv, WIN);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.ena   = ($urandom_range(7) != 0);
            bus.spike = ($urandom_range(2) == 0);
            bus.clear = ($urandom_range(199) == 0);
            cyc();
        end
        bus.clear = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
